hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central stall/flush/forward controller for the 5-stage pipeline.
- Drives the enable (stallX) and clear (flushX) inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC register.
- Drives the ID- and EX-stage forwarding muxes.
- Sequences multi-cycle data-memory waits and the multi-cycle multiply/divide unit (MDU) through an internal FSM and a busy counter.

Parameters:
- MDU_LAT, 32: cycles the MDU is busy after a start is accepted.
- CNT_W, 6: width of the MDU busy counter. Must satisfy 2^CNT_W > MDU_LAT.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rsD, rtD  in  5  source registers of the instruction in ID
- rsE, rtE  in  5  source registers of the instruction in EX
- writeRegE, writeRegM, writeRegW  in  5  destination register per stage
- regWriteE, regWriteM, regWriteW  in  1  register-write enable per stage
- memToRegE, memToRegM  in  1  load in EX / MEM
- branchD  in  1  branch in ID (resolved in ID)
- pcSrcD  in  1  branch in ID is taken
- mduReadD  in  1  mfhi/mflo in ID
- mduStartE  in  1  mult/div in EX requests the MDU
- imemReady  in  1  instruction fetch completes this cycle
- dmemReq  in  1  load/store in MEM
- dmemReady  in  1  data access completes this cycle
- stallF, stallD, stallE, stallM  out  1  hold the PC / IF-ID / ID-EX / EX-MEM registers
- IFflush, flushE, flushM, flushW  out  1  insert a bubble into IF-ID / ID-EX / EX-MEM / MEM-WB
- forwardAD, forwardBD  out  1  forward the MEM result to the ID comparator
- forwardAE, forwardBE  out  2  EX operand select: 00 register file, 10 MEM, 01 WB
- mduBusy  out  1  MDU counter is non-zero

Behaviour:
- Register r0 never matches in any hazard or forwarding compare.
- Forwarding is purely combinational:
  - forwardAE = 10 if regWriteM and writeRegM == rsE.
  - Otherwise forwardAE = 01 if regWriteW and writeRegW == rsE.
  - Otherwise forwardAE = 00.
  - forwardBE: same rules using rtE.
  - forwardAD = regWriteM and writeRegM == rsD. forwardBD: same using rtD.
- Hazard terms:
  - lwstall = memToRegE and rtE in {rsD, rtD}.
  - brstall = branchD and ((regWriteE and writeRegE in {rsD, rtD}) or (memToRegM and writeRegM in {rsD, rtD})).
  - mdustall = mduReadD and mduBusy.
- FSM states and transitions:
  - RUN to DWAIT when dmemReq and not dmemReady.
  - DWAIT to RUN on dmemReady.
- Output priority, first match wins:
  1. state == DWAIT, or RUN with dmemReq and not dmemReady: stallF, stallD, stallE and stallM are 1; flushW is 1. All other flushes are 0.
  2. mduStartE and mduBusy: stallF, stallD and stallE are 1; flushM is 1.
  3. lwstall, brstall or mdustall: stallF and stallD are 1; flushE is 1.
  4. Not imemReady and pcSrcD: stallF and stallD are 1; flushE is 1. This holds the branch in ID until the fetch lands.
  5. Not imemReady: stallF is 1; IFflush is 1.
  6. pcSrcD: IFflush is 1.
  7. Otherwise all stall/flush outputs are 0.
- Invariant: IFflush is never 1 in a cycle where stallD is 1, because the IF/ID register ignores a flush while stalled. The bench checks this every cycle.
- MDU counter:
  - Loads MDU_LAT when mduStartE and not stallE and not mduBusy.
  - Otherwise decrements while non-zero.
  - Saturates at 0.
  - mduBusy is registered: it is 1 from the cycle after the start for exactly MDU_LAT cycles.
- Reset:
  - State goes to RUN and the counter to 0.
  - All registered outputs go to 0.
  - Combinational outputs follow the inputs in the same cycle. Reset does not force them.
  - A reset during DWAIT or during MDU busy aborts it at the next edge.

Decomposition:
- Shared package hazard_pkg holds:
  - FSM state typedef {RUN, DWAIT}
  - forward-select encodings FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - REG_ZERO = 5'd0
- One sub-module, mdu_busy_cnt, contains the counter and mduBusy.

Test Plan:
- Load-use: lw writes $8 (in EX, memToRegE=1, rtE=8), add reads rsD=8 -> exactly one cycle of stallF=stallD=flushE=1 with IFflush=0; next cycle forwardAE=01.
- Branch after ALU: beq rsD=9 while regWriteE=1 and writeRegE=9 -> brstall for 1 cycle, then forwardAD=1 for 1 cycle. Branch after load (writeRegE=9, memToRegE=1) -> 2 stall cycles.
- Taken branch with imemReady=0 for 3 cycles -> stallD=1 and IFflush=0 for those 3 cycles; IFflush=1 in the first cycle with imemReady=1.
- dmem wait: dmemReq=1 with dmemReady low for 4 cycles -> stallF, stallD, stallE, stallM and flushW held 4 cycles; state returns to RUN on dmemReady.
- MDU: mduStartE accepted, then mduReadD on the next cycle -> stall for MDU_LAT (32) cycles; mduBusy falls exactly 32 cycles after it rose.
- Reset asserted mid-DWAIT and mid-MDU -> state RUN and mduBusy 0 one cycle later; no stall asserted while inputs are idle.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    // Data-memory wait sequencer states.
    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DWAIT = 1'b1
    } state_t;

    // EX-stage forwarding mux select encodings.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Hard-wired zero register; it never produces a dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // True when a producer destination feeds a consumer source (r0 excluded).
    function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
        return (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle.
interface hazard_ctrl_if;
    // Register identifiers and write enables per stage
    logic [4:0] rsD, rtD, rsE, rtE;
    logic [4:0] writeRegE, writeRegM, writeRegW;
    logic       regWriteE, regWriteM, regWriteW;
    logic       memToRegE, memToRegM;
    // Control-flow, MDU and memory handshakes
    logic       branchD, pcSrcD;
    logic       mduReadD, mduStartE;
    logic       imemReady, dmemReq, dmemReady;
    // Pipeline register controls
    logic       stallF, stallD, stallE, stallM;
    logic       IFflush, flushE, flushM, flushW;
    // Forwarding selects
    logic       forwardAD, forwardBD;
    logic [1:0] forwardAE, forwardBE;
    logic       mduBusy;

    // Pipeline side: reports stage contents, obeys stall/flush/forward.
    modport master (
        output rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW,
               regWriteE, regWriteM, regWriteW, memToRegE, memToRegM,
               branchD, pcSrcD, mduReadD, mduStartE, imemReady, dmemReq, dmemReady,
        input  stallF, stallD, stallE, stallM, IFflush, flushE, flushM, flushW,
               forwardAD, forwardBD, forwardAE, forwardBE, mduBusy
    );

    // Controller side.
    modport slave (
        input  rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW,
               regWriteE, regWriteM, regWriteW, memToRegE, memToRegM,
               branchD, pcSrcD, mduReadD, mduStartE, imemReady, dmemReq, dmemReady,
        output stallF, stallD, stallE, stallM, IFflush, flushE, flushM, flushW,
               forwardAD, forwardBD, forwardAE, forwardBE, mduBusy
    );
endinterface

// File: rtl/mdu_busy_cnt.sv
// MDU busy counter: busy for exactly MDU_LAT cycles after an accepted start.
module mdu_busy_cnt #(
    parameter int MDU_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_stall,
    output logic o_busy
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_busy;

    // Next count: load on an accepted start, else count down and hold at zero.
    always_comb begin
        // NOTE: default assignment first so no path through this block infers a latch.
        w_cnt_nxt = r_cnt;
        if (i_start && !i_stall && !r_busy)
            w_cnt_nxt = CNT_W'(MDU_LAT);
        else if (r_cnt != '0)
            w_cnt_nxt = r_cnt - 1'b1;
    end

    // Counter and registered busy flag; busy mirrors a non-zero next count.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (rst) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_busy <= (w_cnt_nxt != '0);
        end
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/hazard_ctrl.sv
// Central stall / flush / forward controller for the 5-stage pipeline.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MDU_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic               clk,
    input  logic               rst,
    hazard_ctrl_if.slave       hif
);

    state_t r_state;
    state_t w_state_nxt;
    logic   w_dmem_wait;
    logic   w_lwstall, w_brstall, w_mdustall;
    logic   w_mdu_busy;
    logic   w_stall_e;

    // A data access is outstanding while waiting or when it misses this cycle.
    assign w_dmem_wait = (r_state == DWAIT) || (hif.dmemReq && !hif.dmemReady);

    // Hazard detection terms.
    always_comb begin
        w_lwstall  = hif.memToRegE &&
                     (reg_match(hif.rtE, hif.rsD) || reg_match(hif.rtE, hif.rtD));
        w_brstall  = hif.branchD &&
                     ((hif.regWriteE && (reg_match(hif.writeRegE, hif.rsD) ||
                                         reg_match(hif.writeRegE, hif.rtD))) ||
                      (hif.memToRegM && (reg_match(hif.writeRegM, hif.rsD) ||
                                         reg_match(hif.writeRegM, hif.rtD))));
        w_mdustall = hif.mduReadD && w_mdu_busy;
    end

    // Forwarding selects: MEM result takes precedence over WB.
    always_comb begin
        hif.forwardAE = FWD_RF;
        if (hif.regWriteM && reg_match(hif.writeRegM, hif.rsE))
            hif.forwardAE = FWD_MEM;
        else if (hif.regWriteW && reg_match(hif.writeRegW, hif.rsE))
            hif.forwardAE = FWD_WB;

        hif.forwardBE = FWD_RF;
        if (hif.regWriteM && reg_match(hif.writeRegM, hif.rtE))
            hif.forwardBE = FWD_MEM;
        else if (hif.regWriteW && reg_match(hif.writeRegW, hif.rtE))
            hif.forwardBE = FWD_WB;

        hif.forwardAD = hif.regWriteM && reg_match(hif.writeRegM, hif.rsD);
        hif.forwardBD = hif.regWriteM && reg_match(hif.writeRegM, hif.rtD);
    end

    // Stall/flush priority; IFflush is only raised when IF/ID is not held.
    always_comb begin
        hif.stallF  = 1'b0;
        hif.stallD  = 1'b0;
        w_stall_e   = 1'b0;
        hif.stallM  = 1'b0;
        hif.IFflush = 1'b0;
        hif.flushE  = 1'b0;
        hif.flushM  = 1'b0;
        hif.flushW  = 1'b0;
        if (w_dmem_wait) begin
            hif.stallF = 1'b1;
            hif.stallD = 1'b1;
            w_stall_e  = 1'b1;
            hif.stallM = 1'b1;
            hif.flushW = 1'b1;
        end else if (hif.mduStartE && w_mdu_busy) begin
            hif.stallF = 1'b1;
            hif.stallD = 1'b1;
            w_stall_e  = 1'b1;
            hif.flushM = 1'b1;
        end else if (w_lwstall || w_brstall || w_mdustall) begin
            hif.stallF = 1'b1;
            hif.stallD = 1'b1;
            hif.flushE = 1'b1;
        end else if (!hif.imemReady && hif.pcSrcD) begin
            // Hold the taken branch in ID until its target fetch lands.
            hif.stallF = 1'b1;
            hif.stallD = 1'b1;
            hif.flushE = 1'b1;
        end else if (!hif.imemReady) begin
            hif.stallF  = 1'b1;
            hif.IFflush = 1'b1;
        end else if (hif.pcSrcD) begin
            hif.IFflush = 1'b1;
        end
    end

    assign hif.stallE = w_stall_e;

    // Data-memory wait sequencer next state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (hif.dmemReq && !hif.dmemReady) w_state_nxt = DWAIT;
            DWAIT:   if (hif.dmemReady)                 w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    // State register; a synchronous reset aborts any pending wait.
    always_ff @(posedge clk) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_state_nxt;
    end

    mdu_busy_cnt #(
        .MDU_LAT (MDU_LAT),
        .CNT_W   (CNT_W)
    ) u_mdu_busy_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_start (hif.mduStartE),
        .i_stall (w_stall_e),
        .o_busy  (w_mdu_busy)
    );

    assign hif.mduBusy = w_mdu_busy;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl.
module tb_hazard_ctrl;

    // Control word order: stallF stallD stallE stallM IFflush flushE flushM flushW
    localparam logic [7:0] C_NONE = 8'b0000_0000;
    localparam logic [7:0] C_DMEM = 8'b1111_0001;
    localparam logic [7:0] C_MDU  = 8'b1110_0010;
    localparam logic [7:0] C_HAZ  = 8'b1100_0100;
    localparam logic [7:0] C_IMEM = 8'b1000_1000;
    localparam logic [7:0] C_BR   = 8'b0000_1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    hazard_ctrl_if hif ();

    hazard_ctrl #(.MDU_LAT(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .hif (hif.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ctl();
        return {hif.stallF, hif.stallD, hif.stallE, hif.stallM,
                hif.IFflush, hif.flushE, hif.flushM, hif.flushW};
    endfunction

    // IF/ID must never see a flush while it is held.
    always @(negedge clk) begin
        #2;
        n_vec++;
        if ((hif.stallD && hif.IFflush) !== 1'b0) begin
            n_err++;
            $display("FAIL invariant_ifflush_stallD t=%0t stallD=%b IFflush=%b required not both 1",
                     $time, hif.stallD, hif.IFflush);
        end
    end

    task automatic idle();
        hif.rsD = 0; hif.rtD = 0; hif.rsE = 0; hif.rtE = 0;
        hif.writeRegE = 0; hif.writeRegM = 0; hif.writeRegW = 0;
        hif.regWriteE = 0; hif.regWriteM = 0; hif.regWriteW = 0;
        hif.memToRegE = 0; hif.memToRegM = 0;
        hif.branchD = 0; hif.pcSrcD = 0; hif.mduReadD = 0; hif.mduStartE = 0;
        hif.imemReady = 1; hif.dmemReq = 0; hif.dmemReady = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        n_vec++;
        if (ctl() !== C_NONE) begin
            n_err++; $display("FAIL reset_ctl got=%b exp=%b", ctl(), C_NONE);
        end
        n_vec++;
        if (hif.mduBusy !== 1'b0) begin
            n_err++; $display("FAIL reset_busy got=%b exp=0", hif.mduBusy);
        end
        rst = 1'b0;
    endtask

    task automatic test_forwarding();
        @(negedge clk); idle();
        hif.regWriteM = 1; hif.writeRegM = 5; hif.regWriteW = 1; hif.writeRegW = 5;
        hif.rsE = 5; hif.rtE = 6; #1;
        n_vec++;
        if ({hif.forwardAE, hif.forwardBE} !== 4'b10_00) begin
            n_err++; $display("FAIL fwd_mem_over_wb got=%b exp=1000", {hif.forwardAE, hif.forwardBE});
        end
        hif.regWriteM = 0; #1;
        n_vec++;
        if (hif.forwardAE !== 2'b01) begin
            n_err++; $display("FAIL fwd_wb got=%b exp=01", hif.forwardAE);
        end
        hif.regWriteM = 1; hif.writeRegM = 0; hif.writeRegW = 0; hif.rsE = 0; hif.rtE = 0; #1;
        n_vec++;
        if ({hif.forwardAE, hif.forwardBE} !== 4'b00_00) begin
            n_err++; $display("FAIL fwd_r0_exec got=%b exp=0000", {hif.forwardAE, hif.forwardBE});
        end
        hif.writeRegM = 7; hif.rtE = 7; hif.rsD = 7; hif.rtD = 3; #1;
        n_vec++;
        if ({hif.forwardBE, hif.forwardAD, hif.forwardBD} !== 4'b10_1_0) begin
            n_err++; $display("FAIL fwd_rt_and_id got=%b exp=1010", {hif.forwardBE, hif.forwardAD, hif.forwardBD});
        end
        hif.writeRegM = 0; hif.rsD = 0; hif.rtD = 0; #1;
        n_vec++;
        if ({hif.forwardAD, hif.forwardBD} !== 2'b00) begin
            n_err++; $display("FAIL fwd_r0_id got=%b exp=00", {hif.forwardAD, hif.forwardBD});
        end
    endtask

    task automatic test_load_use();
        // lw $8 in EX, add reads $8 in ID
        @(negedge clk); idle();
        hif.memToRegE = 1; hif.regWriteE = 1; hif.writeRegE = 8; hif.rtE = 8; hif.rsD = 8; #1;
        n_vec++;
        if (ctl() !== C_HAZ) begin
            n_err++; $display("FAIL loaduse_stall got=%b exp=%b", ctl(), C_HAZ);
        end
        // bubble in EX, lw in MEM, add still in ID
        @(negedge clk); idle();
        hif.memToRegM = 1; hif.regWriteM = 1; hif.writeRegM = 8; hif.rsD = 8; #1;
        n_vec++;
        if (ctl() !== C_NONE) begin
            n_err++; $display("FAIL loaduse_release got=%b exp=%b", ctl(), C_NONE);
        end
        // lw in WB, add in EX
        @(negedge clk); idle();
        hif.regWriteW = 1; hif.writeRegW = 8; hif.rsE = 8; hif.rtE = 2; #1;
        n_vec++;
        if ({hif.forwardAE, hif.forwardBE} !== 4'b01_00) begin
            n_err++; $display("FAIL loaduse_fwd got=%b exp=0100", {hif.forwardAE, hif.forwardBE});
        end
    endtask

    task automatic test_branch();
        // ALU result for $9 in EX, beq on $9 in ID
        @(negedge clk); idle();
        hif.branchD = 1; hif.rsD = 9; hif.rtD = 4; hif.regWriteE = 1; hif.writeRegE = 9; #1;
        n_vec++;
        if (ctl() !== C_HAZ) begin
            n_err++; $display("FAIL br_alu_stall got=%b exp=%b", ctl(), C_HAZ);
        end
        @(negedge clk); idle();
        hif.branchD = 1; hif.rsD = 9; hif.rtD = 4; hif.regWriteM = 1; hif.writeRegM = 9; #1;
        n_vec++;
        if ({ctl(), hif.forwardAD, hif.forwardBD} !== {C_NONE, 2'b10}) begin
            n_err++; $display("FAIL br_alu_fwd got=%b exp=%b", {ctl(), hif.forwardAD, hif.forwardBD}, {C_NONE, 2'b10});
        end
        // load into $9 in EX, beq on $9
        @(negedge clk); idle();
        hif.branchD = 1; hif.rsD = 9; hif.regWriteE = 1; hif.writeRegE = 9; hif.memToRegE = 1; hif.rtE = 9; #1;
        n_vec++;
        if (ctl() !== C_HAZ) begin
            n_err++; $display("FAIL br_ld_stall1 got=%b exp=%b", ctl(), C_HAZ);
        end
        @(negedge clk); idle();
        hif.branchD = 1; hif.rsD = 9; hif.regWriteM = 1; hif.writeRegM = 9; hif.memToRegM = 1; #1;
        n_vec++;
        if (ctl() !== C_HAZ) begin
            n_err++; $display("FAIL br_ld_stall2 got=%b exp=%b", ctl(), C_HAZ);
        end
        @(negedge clk); idle();
        hif.branchD = 1; hif.rsD = 9; hif.regWriteW = 1; hif.writeRegW = 9; #1;
        n_vec++;
        if ({ctl(), hif.forwardAD} !== {C_NONE, 1'b0}) begin
            n_err++; $display("FAIL br_ld_release got=%b exp=%b", {ctl(), hif.forwardAD}, {C_NONE, 1'b0});
        end
    endtask

    task automatic test_imem();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle();
            hif.branchD = 1; hif.pcSrcD = 1; hif.imemReady = 0; #1;
            n_vec++;
            if (ctl() !== C_HAZ) begin
                n_err++; $display("FAIL br_imem_hold%0d got=%b exp=%b", i, ctl(), C_HAZ);
            end
        end
        @(negedge clk); idle();
        hif.branchD = 1; hif.pcSrcD = 1; #1;
        n_vec++;
        if (ctl() !== C_BR) begin
            n_err++; $display("FAIL br_imem_land got=%b exp=%b", ctl(), C_BR);
        end
        @(negedge clk); idle();
        hif.imemReady = 0; #1;
        n_vec++;
        if (ctl() !== C_IMEM) begin
            n_err++; $display("FAIL imem_miss got=%b exp=%b", ctl(), C_IMEM);
        end
    endtask

    task automatic test_dmem_wait();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); idle();
            hif.dmemReq = 1;
            // a simultaneous load-use must not leak a flushE
            hif.memToRegE = 1; hif.rtE = 3; hif.rsD = 3; #1;
            n_vec++;
            if (ctl() !== C_DMEM) begin
                n_err++; $display("FAIL dmem_wait%0d got=%b exp=%b", i, ctl(), C_DMEM);
            end
        end
        // completion cycle is still in DWAIT
        @(negedge clk); idle();
        hif.dmemReq = 1; hif.dmemReady = 1; #1;
        n_vec++;
        if (ctl() !== C_DMEM) begin
            n_err++; $display("FAIL dmem_ready got=%b exp=%b", ctl(), C_DMEM);
        end
        @(negedge clk); idle(); #1;
        n_vec++;
        if (ctl() !== C_NONE) begin
            n_err++; $display("FAIL dmem_back_run got=%b exp=%b", ctl(), C_NONE);
        end
        // a hit in RUN does not stall
        @(negedge clk); idle();
        hif.dmemReq = 1; hif.dmemReady = 1; #1;
        n_vec++;
        if (ctl() !== C_NONE) begin
            n_err++; $display("FAIL dmem_hit got=%b exp=%b", ctl(), C_NONE);
        end
    endtask

    task automatic test_mdu();
        int busy_cycles;
        int stall_ok;
        busy_cycles = 0;
        stall_ok    = 0;
        @(negedge clk); idle();
        hif.mduStartE = 1; #1;
        n_vec++;
        if ({ctl(), hif.mduBusy} !== {C_NONE, 1'b0}) begin
            n_err++; $display("FAIL mdu_start got=%b exp=%b", {ctl(), hif.mduBusy}, {C_NONE, 1'b0});
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); idle();
            hif.mduReadD = 1; #1;
            if (!hif.mduBusy) break;
            busy_cycles++;
            if (ctl() === C_HAZ) stall_ok++;
        end
        n_vec++;
        if (busy_cycles !== 32) begin
            n_err++; $display("FAIL mdu_busy_len got=%0d exp=32", busy_cycles);
        end
        n_vec++;
        if (stall_ok !== 32) begin
            n_err++; $display("FAIL mdu_stall_len got=%0d exp=32", stall_ok);
        end
        n_vec++;
        if (ctl() !== C_NONE) begin
            n_err++; $display("FAIL mdu_release got=%b exp=%b", ctl(), C_NONE);
        end
    endtask

    task automatic test_mdu_conflict_reset();
        @(negedge clk); idle();
        hif.mduStartE = 1; #1;
        // second mult/div while busy, with a load-use also present
        @(negedge clk); idle();
        hif.mduStartE = 1; hif.memToRegE = 1; hif.rtE = 4; hif.rtD = 4; #1;
        n_vec++;
        if ({ctl(), hif.mduBusy} !== {C_MDU, 1'b1}) begin
            n_err++; $display("FAIL mdu_conflict got=%b exp=%b", {ctl(), hif.mduBusy}, {C_MDU, 1'b1});
        end
        @(negedge clk); idle();
        rst = 1'b1; #1;
        n_vec++;
        if (hif.mduBusy !== 1'b1) begin
            n_err++; $display("FAIL mdu_rst_sync got=%b exp=1", hif.mduBusy);
        end
        @(negedge clk); rst = 1'b0; idle();
        hif.mduReadD = 1; #1;
        n_vec++;
        if ({ctl(), hif.mduBusy} !== {C_NONE, 1'b0}) begin
            n_err++; $display("FAIL mdu_rst_abort got=%b exp=%b", {ctl(), hif.mduBusy}, {C_NONE, 1'b0});
        end
    endtask

    task automatic test_reset_dwait();
        repeat (2) begin
            @(negedge clk); idle();
            hif.dmemReq = 1; #1;
        end
        // reset cycle: state still DWAIT, outputs follow it
        @(negedge clk); idle();
        rst = 1'b1; #1;
        n_vec++;
        if (ctl() !== C_DMEM) begin
            n_err++; $display("FAIL dwait_rst_cycle got=%b exp=%b", ctl(), C_DMEM);
        end
        @(negedge clk); rst = 1'b0; idle(); #1;
        n_vec++;
        if (ctl() !== C_NONE) begin
            n_err++; $display("FAIL dwait_rst_abort got=%b exp=%b", ctl(), C_NONE);
        end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_imem();
        test_dmem_wait();
        test_mdu();
        test_mdu_conflict_reset();
        test_reset_dwait();
        @(negedge clk); #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
